calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Parametrised successor to the calculator control FSM. It sequences button entry, chained binary operations, repeat-equals, negation and error recovery between the button decoder, the external ALU and the display driver. The datapath width and the entry radix are configurable. It sits between the keypad debouncer/encoder and the ALU/display blocks, and all three sides use valid/ready handshakes.

## Interface
- `DATA_WIDTH`, default 16: operand, result and display width; must be at least 4.
- `HEX_ENTRY`, default 0: 0 accepts decimal digits 0-9, 1 accepts hex digits 0-15.
- `clk` in 1: single clock. Reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_button_data` in 5: bit4=0 is digit (value = bits[3:0]). 10000 ADD, 10001 SUB, 10010 MUL, 10011 DIV, 10100 EQ, 10101 AC, 10110 NEG; other codes are ignored.
- `i_button_valid` in 1 / `o_button_ready` out 1: button handshake.
- `i_2s_comp_mode` in 1: signed mode; captured into `o_alu_input_signed` at each ALU request.
- `o_alu_input_a`, `o_alu_input_b` out DATA_WIDTH; `o_alu_input_op` out 2 (00 ADD, 01 SUB, 10 MUL, 11 DIV); `o_alu_input_signed` out 1.
- `o_alu_input_valid` out 1 / `i_alu_input_ready` in 1: ALU request handshake.
- `i_alu_result` in DATA_WIDTH; `i_alu_error` in 1.
- `i_alu_result_valid` in 1 / `o_alu_result_ready` out 1: ALU response handshake.
- `o_add_state_display`, `o_sub_state_display`, `o_mul_state_display`, `o_div_state_display` out 1 each: one-hot pending operator, all 0 when no operator is pending.
- `o_error` out 1: high in the ERROR state.
- `o_display_data` out DATA_WIDTH; `o_display_2s_comp` out 1 (equals `i_2s_comp_mode`).
- `o_display_valid` out 1 / `i_display_ready` in 1; `i_display_done` in 1: the display has finished rendering.

## Operation
- Registers:
  - A (accumulator) and B (second operand).
  - `op` (2 bit).
  - Flags: `op_pend`, `b_started`, `rep_valid`, `after_eq`.
- States: CLEAR, IDLE, DISP, DISP_WAIT, ALU_REQ, ALU_WAIT, ERROR.
- CLEAR: zeros every register and flag, then goes to DISP showing 0.
- IDLE and ERROR are the only states with `o_button_ready`=1. Every key accepted there is consumed, including ignored ones.
- Digit d:
  - Rejected (dropped, no display) if `HEX_ENTRY`=0 and d>9.
  - If `after_eq`=1, A is cleared first.
  - If `op_pend` and !`b_started`: B=d, `b_started`=1.
  - Otherwise the current operand X (B if `b_started`, else A) becomes X*R+d, with R=10 or 16, truncated mod 2^DATA_WIDTH.
  - Then go to DISP.
- NEG:
  - Current operand becomes its two's complement (0-X mod 2^W).
  - If `op_pend` and !`b_started`: B=-A and `b_started`=1.
  - Then go to DISP.
- Operator key:
  - If `op_pend` and `b_started`: issue A op B to the ALU. On the result, A=result, then `op`=new key and go to DISP.
  - Otherwise: `op`=new key with no display refresh.
  - Either way, afterwards `op_pend`=1, `b_started`=0, `after_eq`=0.
- EQ:
  - If `op_pend`: when !`b_started`, B=A (square/self-op). Then A op B; A=result.
  - On completion: `op_pend`=0, `b_started`=0, `rep_valid`=1, `after_eq`=1.
  - If !`op_pend` and `rep_valid`: repeat A op B with the saved B and op.
  - Otherwise: redisplay A.
- AC: go to CLEAR from IDLE or ERROR.
- Displayed value: B when `b_started`, else A.
- ALU_REQ/ALU_WAIT:
  - ALU_REQ holds valid, A, B, op and signed until ready, then moves to ALU_WAIT.
  - ALU_WAIT holds `o_alu_result_ready`=1 until the result is valid.
  - Result with `i_alu_error`=1: go to ERROR; A and B are unchanged.
- ERROR: `o_error`=1; the display is not refreshed. Every key except AC is accepted and dropped.
- DISP holds `o_display_valid` until ready, then moves to DISP_WAIT. DISP_WAIT stays until `i_display_done`, then returns to IDLE.

## Timing
- Reset (`rst_n` low): all outputs 0 and state CLEAR.
  - First cycle after release: CLEAR.
  - Next cycle: DISP with `o_display_valid`=1 and data 0.
- Button accepted at edge N: registers update at N. At N+1 the block is in DISP (valid high) or ALU_REQ (valid high).
- Handshakes transfer on an edge where valid and ready are both 1. Payload is stable while valid is high.
- `i_display_done` and `i_alu_result_valid` are ignored outside DISP_WAIT and ALU_WAIT respectively.
- `i_display_done` asserted in the same cycle as the display handshake does not count; it must be sampled in DISP_WAIT.
- Indicator outputs change on the edge that updates `op_pend`/`op`.
- Reset mid-transaction drops all valids immediately (asynchronously).

## Test plan
- Reset, then keys 1, 2:
  - Display 0, then 1, then 12.
  - `o_button_ready`=0 from the key accept until after `i_display_done`.
- Keys 1, 2, ADD, 3, EQ:
  - ALU sees a=12, b=3, op=00; display 15.
  - EQ again: a=15, b=3; display 18.
  - Key 4: display 4 (fresh entry).
- Chain 5, ADD, 3, SUB:
  - ALU 5+3; display 8; `o_sub_state_display`=1.
  - Then 2, EQ: ALU a=8, b=2, op=01; display 6; all indicators 0.
- Keys 7, MUL, EQ:
  - B copied: a=7, b=7, op=10; display 49.
  - NEG: display 0xFFCF (16-bit).
- Keys 9, DIV, 0, EQ with the ALU returning error:
  - `o_error`=1; keys 3 and ADD are accepted with no display and no ALU request.
  - AC: display 0 and `o_error`=0.
- `HEX_ENTRY`=1, keys 10, 15: display 0x00AF.
- `HEX_ENTRY`=0: key 12 is dropped with no display. Seven presses of 9 display 9999999 mod 65536 = 38527.
- ALU ready and display ready held low for 5 cycles: payload stable throughout.

Source files
------------

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator key sequencer between keypad, ALU and display
module calc_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter bit HEX_ENTRY  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            i_button_data,
  input  logic                  i_button_valid,
  output logic                  o_button_ready,
  input  logic                  i_2s_comp_mode,
  output logic [DATA_WIDTH-1:0] o_alu_input_a,
  output logic [DATA_WIDTH-1:0] o_alu_input_b,
  output logic [1:0]            o_alu_input_op,
  output logic                  o_alu_input_signed,
  output logic                  o_alu_input_valid,
  input  logic                  i_alu_input_ready,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_error,
  input  logic                  i_alu_result_valid,
  output logic                  o_alu_result_ready,
  output logic                  o_add_state_display,
  output logic                  o_sub_state_display,
  output logic                  o_mul_state_display,
  output logic                  o_div_state_display,
  output logic                  o_error,
  output logic [DATA_WIDTH-1:0] o_display_data,
  output logic                  o_display_2s_comp,
  output logic                  o_display_valid,
  input  logic                  i_display_ready,
  input  logic                  i_display_done
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_DISP, S_DISP_WAIT, S_ALU_REQ, S_ALU_WAIT, S_ERROR
  } state_t;

  localparam logic [4:0] K_EQ  = 5'b10100;
  localparam logic [4:0] K_AC  = 5'b10101;
  localparam logic [4:0] K_NEG = 5'b10110;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] a_reg, b_reg;
  logic [1:0]            op, next_op;
  logic                  op_pend, b_started, rep_valid, after_eq;
  logic                  alu_eq, alu_signed;

  logic                  key_fire, is_digit, is_oper, digit_ok;
  logic [DATA_WIDTH-1:0] digit_ext, cur, cur_times_r, entered;

  assign key_fire    = i_button_valid && o_button_ready;
  assign is_digit    = !i_button_data[4];
  assign is_oper     = (i_button_data[4:2] == 3'b100);
  assign digit_ok    = HEX_ENTRY || (i_button_data[3:0] <= 4'd9);
  assign digit_ext   = DATA_WIDTH'(i_button_data[3:0]);
  assign cur         = b_started ? b_reg : a_reg;
  assign cur_times_r = HEX_ENTRY ? (cur << 4) : ((cur << 3) + (cur << 1));
  assign entered     = cur_times_r + digit_ext;

  assign o_alu_input_a       = a_reg;
  assign o_alu_input_b       = b_reg;
  assign o_alu_input_op      = op;
  assign o_alu_input_signed  = alu_signed;
  assign o_display_data      = cur;
  assign o_display_2s_comp   = i_2s_comp_mode;
  assign o_add_state_display = op_pend && (op == 2'b00);
  assign o_sub_state_display = op_pend && (op == 2'b01);
  assign o_mul_state_display = op_pend && (op == 2'b10);
  assign o_div_state_display = op_pend && (op == 2'b11);

  // State register; reset parks in CLEAR so every handshake valid drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= next_state;
  end

  // Next-state decode and handshake strobes.
  always_comb begin
    next_state         = state;
    o_button_ready     = 1'b0;
    o_display_valid    = 1'b0;
    o_alu_input_valid  = 1'b0;
    o_alu_result_ready = 1'b0;
    o_error            = 1'b0;
    case (state)
      S_CLEAR: next_state = S_DISP;
      S_IDLE: begin
        o_button_ready = 1'b1;
        if (key_fire) begin
          if (is_digit) begin
            if (digit_ok) next_state = S_DISP;
          end else if (is_oper) begin
            if (op_pend && b_started) next_state = S_ALU_REQ;
          end else if (i_button_data == K_EQ) begin
            next_state = (op_pend || rep_valid) ? S_ALU_REQ : S_DISP;
          end else if (i_button_data == K_AC) begin
            next_state = S_CLEAR;
          end else if (i_button_data == K_NEG) begin
            next_state = S_DISP;
          end
        end
      end
      S_DISP: begin
        o_display_valid = 1'b1;
        if (i_display_ready) next_state = S_DISP_WAIT;
      end
      S_DISP_WAIT: if (i_display_done) next_state = S_IDLE;
      S_ALU_REQ: begin
        o_alu_input_valid = 1'b1;
        if (i_alu_input_ready) next_state = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        o_alu_result_ready = 1'b1;
        if (i_alu_result_valid) next_state = i_alu_error ? S_ERROR : S_DISP;
      end
      S_ERROR: begin
        o_button_ready = 1'b1;
        o_error        = 1'b1;
        if (key_fire && (i_button_data == K_AC)) next_state = S_CLEAR;
      end
      default: next_state = S_CLEAR;
    endcase
  end

  // Operand, operator and flag updates on accepted keys and ALU results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0; b_reg <= '0; op <= 2'b00; next_op <= 2'b00;
      op_pend <= 1'b0; b_started <= 1'b0; rep_valid <= 1'b0; after_eq <= 1'b0;
      alu_eq <= 1'b0; alu_signed <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          a_reg <= '0; b_reg <= '0; op <= 2'b00; next_op <= 2'b00;
          op_pend <= 1'b0; b_started <= 1'b0; rep_valid <= 1'b0; after_eq <= 1'b0;
          alu_eq <= 1'b0; alu_signed <= 1'b0;
        end
        S_IDLE: begin
          if (key_fire) begin
            if (is_digit) begin
              if (digit_ok) begin
                if (after_eq) begin
                  a_reg    <= digit_ext;
                  after_eq <= 1'b0;
                end else if (op_pend && !b_started) begin
                  b_reg     <= digit_ext;
                  b_started <= 1'b1;
                end else if (b_started) begin
                  b_reg <= entered;
                end else begin
                  a_reg <= entered;
                end
              end
            end else if (is_oper) begin
              if (op_pend && b_started) begin
                // Chained operator: the new op takes effect once the pending one resolves.
                next_op    <= i_button_data[1:0];
                alu_eq     <= 1'b0;
                alu_signed <= i_2s_comp_mode;
              end else begin
                op        <= i_button_data[1:0];
                op_pend   <= 1'b1;
                b_started <= 1'b0;
                after_eq  <= 1'b0;
              end
            end else if (i_button_data == K_EQ) begin
              if (op_pend) begin
                if (!b_started) b_reg <= a_reg;
                alu_eq     <= 1'b1;
                alu_signed <= i_2s_comp_mode;
              end else if (rep_valid) begin
                alu_eq     <= 1'b1;
                alu_signed <= i_2s_comp_mode;
              end
            end else if (i_button_data == K_NEG) begin
              if (op_pend && !b_started) begin
                b_reg     <= -a_reg;
                b_started <= 1'b1;
              end else if (b_started) begin
                b_reg <= -b_reg;
              end else begin
                a_reg <= -a_reg;
              end
            end
          end
        end
        S_ALU_WAIT: begin
          if (i_alu_result_valid && !i_alu_error) begin
            a_reg     <= i_alu_result;
            b_started <= 1'b0;
            if (alu_eq) begin
              op_pend   <= 1'b0;
              rep_valid <= 1'b1;
              after_eq  <= 1'b1;
            end else begin
              op       <= next_op;
              op_pend  <= 1'b1;
              after_eq <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btn_data = '0;
  logic        bv = 1'b0, bv_h = 1'b0;
  logic        mode = 1'b0;
  logic        alu_rdy = 1'b0, alu_err = 1'b0, alu_rv = 1'b0;
  logic [15:0] alu_res = '0;
  logic        disp_rdy = 1'b0, disp_done = 1'b0;

  logic        rdy, aval, signd, rres, add_i, sub_i, mul_i, div_i, err, d2c, dval;
  logic [15:0] a, b, dd;
  logic [1:0]  aop;
  logic        rdy_h, aval_h, signd_h, rres_h, add_h, sub_h, mul_h, div_h, err_h, d2c_h, dval_h;
  logic [15:0] a_h, b_h, dd_h;
  logic [1:0]  aop_h;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.DATA_WIDTH(16), .HEX_ENTRY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .i_button_data(btn_data), .i_button_valid(bv),
    .o_button_ready(rdy), .i_2s_comp_mode(mode), .o_alu_input_a(a), .o_alu_input_b(b),
    .o_alu_input_op(aop), .o_alu_input_signed(signd), .o_alu_input_valid(aval),
    .i_alu_input_ready(alu_rdy), .i_alu_result(alu_res), .i_alu_error(alu_err),
    .i_alu_result_valid(alu_rv), .o_alu_result_ready(rres),
    .o_add_state_display(add_i), .o_sub_state_display(sub_i),
    .o_mul_state_display(mul_i), .o_div_state_display(div_i), .o_error(err),
    .o_display_data(dd), .o_display_2s_comp(d2c), .o_display_valid(dval),
    .i_display_ready(disp_rdy), .i_display_done(disp_done)
  );

  calc_sequencer #(.DATA_WIDTH(16), .HEX_ENTRY(1'b1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .i_button_data(btn_data), .i_button_valid(bv_h),
    .o_button_ready(rdy_h), .i_2s_comp_mode(mode), .o_alu_input_a(a_h), .o_alu_input_b(b_h),
    .o_alu_input_op(aop_h), .o_alu_input_signed(signd_h), .o_alu_input_valid(aval_h),
    .i_alu_input_ready(alu_rdy), .i_alu_result(alu_res), .i_alu_error(alu_err),
    .i_alu_result_valid(alu_rv), .o_alu_result_ready(rres_h),
    .o_add_state_display(add_h), .o_sub_state_display(sub_h),
    .o_mul_state_display(mul_h), .o_div_state_display(div_h), .o_error(err_h),
    .o_display_data(dd_h), .o_display_2s_comp(d2c_h), .o_display_valid(dval_h),
    .i_display_ready(disp_rdy), .i_display_done(disp_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input bit h, input logic [4:0] code);
    int n = 0;
    @(negedge clk);
    while (!(h ? rdy_h : rdy) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("press_timeout", 0, 1);
    btn_data = code;
    if (h) bv_h = 1'b1; else bv = 1'b1;
    @(posedge clk); #1;
    bv = 1'b0; bv_h = 1'b0;
  endtask

  task automatic expect_disp(input bit h, input string tag, input logic [15:0] exp, input int stall);
    int n = 0;
    bit busy_ok = 1'b1;
    bit stable = 1'b1;
    @(negedge clk);
    while (!(h ? dval_h : dval) && n < 50) begin
      if (h ? rdy_h : rdy) busy_ok = 1'b0;
      @(negedge clk); n++;
    end
    check({tag, "_dvalid"}, h ? dval_h : dval, 1);
    if (h ? dval_h : dval) begin
      check(tag, h ? dd_h : dd, exp);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!(h ? dval_h : dval) || ((h ? dd_h : dd) !== exp) || (h ? rdy_h : rdy)) stable = 1'b0;
      end
      if (stall > 0) check({tag, "_stable"}, stable, 1);
      disp_rdy = 1'b1; disp_done = 1'b1;
      @(posedge clk); #1;
      disp_rdy = 1'b0; disp_done = 1'b0;
      @(negedge clk);
      if ((h ? rdy_h : rdy) || (h ? dval_h : dval)) busy_ok = 1'b0;
      check({tag, "_busy"}, busy_ok, 1);
      disp_done = 1'b1;
      @(posedge clk); #1;
      disp_done = 1'b0;
      @(negedge clk);
      check({tag, "_rdy_after"}, h ? rdy_h : rdy, 1);
    end
  endtask

  task automatic expect_alu(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                            input logic [1:0] eop, input logic [15:0] res, input bit e, input int stall);
    int n = 0;
    bit stable = 1'b1;
    @(negedge clk);
    while (!aval && n < 50) begin @(negedge clk); n++; end
    check({tag, "_avalid"}, aval, 1);
    if (aval) begin
      check({tag, "_a"}, a, ea);
      check({tag, "_b"}, b, eb);
      check({tag, "_op"}, aop, eop);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!aval || a !== ea || b !== eb || aop !== eop || rres) stable = 1'b0;
      end
      if (stall > 0) check({tag, "_stable"}, stable, 1);
      alu_rdy = 1'b1;
      @(posedge clk); #1;
      alu_rdy = 1'b0;
      @(negedge clk);
      check({tag, "_rres"}, rres, 1);
      alu_res = res; alu_err = e; alu_rv = 1'b1;
      @(posedge clk); #1;
      alu_rv = 1'b0; alu_err = 1'b0;
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit quiet = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dval || aval) quiet = 1'b0;
    end
    check(tag, quiet, 1);
  endtask

  logic [15:0] model;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dval", dval, 0);
    check("rst_aval", aval, 0);
    check("rst_rdy", rdy, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    expect_disp(0, "rst_disp", 16'd0, 0);

    press(0, 5'd1);  expect_disp(0, "k1", 16'd1, 0);
    press(0, 5'd2);  expect_disp(0, "k12", 16'd12, 0);
    press(0, 5'b10000);
    expect_quiet("add_quiet", 3);
    check("add_ind", {add_i, sub_i, mul_i, div_i}, 4'b1000);
    press(0, 5'd3);  expect_disp(0, "k3", 16'd3, 0);
    press(0, 5'b10100);
    expect_alu("eq1", 16'd12, 16'd3, 2'b00, 16'd15, 1'b0, 0);
    expect_disp(0, "eq1_disp", 16'd15, 0);
    press(0, 5'b10100);
    expect_alu("eq2", 16'd15, 16'd3, 2'b00, 16'd18, 1'b0, 0);
    expect_disp(0, "eq2_disp", 16'd18, 0);
    press(0, 5'd4);  expect_disp(0, "fresh4", 16'd4, 0);

    press(0, 5'b10101); expect_disp(0, "ac1", 16'd0, 0);
    press(0, 5'd5);  expect_disp(0, "k5", 16'd5, 0);
    press(0, 5'b10000);
    press(0, 5'd3);  expect_disp(0, "k3b", 16'd3, 0);
    press(0, 5'b10001);
    expect_alu("chain", 16'd5, 16'd3, 2'b00, 16'd8, 1'b0, 0);
    expect_disp(0, "chain_disp", 16'd8, 0);
    check("sub_ind", {add_i, sub_i, mul_i, div_i}, 4'b0100);
    press(0, 5'd2);  expect_disp(0, "k2b", 16'd2, 0);
    press(0, 5'b10100);
    expect_alu("sub_eq", 16'd8, 16'd2, 2'b01, 16'd6, 1'b0, 0);
    expect_disp(0, "sub_disp", 16'd6, 0);
    check("ind_clear", {add_i, sub_i, mul_i, div_i}, 4'b0000);

    press(0, 5'b10101); expect_disp(0, "ac2", 16'd0, 0);
    press(0, 5'd7);  expect_disp(0, "k7", 16'd7, 0);
    press(0, 5'b10010);
    check("mul_ind", {add_i, sub_i, mul_i, div_i}, 4'b0010);
    mode = 1'b1;
    press(0, 5'b10100);
    mode = 1'b0;
    @(negedge clk);
    check("signed_cap", signd, 1);
    check("disp_2s", d2c, 0);
    expect_alu("sq", 16'd7, 16'd7, 2'b10, 16'd49, 1'b0, 0);
    expect_disp(0, "sq_disp", 16'd49, 0);
    press(0, 5'b10110); expect_disp(0, "neg", 16'hFFCF, 0);

    press(0, 5'b10101); expect_disp(0, "ac3", 16'd0, 0);
    press(0, 5'd9);  expect_disp(0, "k9", 16'd9, 0);
    press(0, 5'b10011);
    press(0, 5'd0);  expect_disp(0, "k0", 16'd0, 0);
    press(0, 5'b10100);
    expect_alu("div0", 16'd9, 16'd0, 2'b11, 16'd0, 1'b1, 0);
    @(negedge clk);
    check("err_set", err, 1);
    press(0, 5'd3);
    press(0, 5'b10000);
    expect_quiet("err_quiet", 4);
    check("err_hold", err, 1);
    press(0, 5'b10101); expect_disp(0, "err_ac", 16'd0, 0);
    check("err_clr", err, 0);

    press(0, 5'd12);
    expect_quiet("dec_reject", 4);
    check("reject_rdy", rdy, 1);
    model = 16'd0;
    for (int i = 0; i < 7; i++) begin
      model = model * 16'd10 + 16'd9;
      press(0, 5'd9);
      expect_disp(0, "nines", model, 0);
    end
    check("nines_final", model, 16'd38527);

    press(0, 5'b10101); expect_disp(0, "ac4", 16'd0, 0);
    press(0, 5'd1);  expect_disp(0, "s1", 16'd1, 0);
    press(0, 5'b10000);
    press(0, 5'd2);  expect_disp(0, "s2", 16'd2, 0);
    press(0, 5'b10100);
    expect_alu("stall", 16'd1, 16'd2, 2'b00, 16'd3, 1'b0, 5);
    expect_disp(0, "stall_disp", 16'd3, 5);

    press(1, 5'd10); expect_disp(1, "hexA", 16'h000A, 0);
    press(1, 5'd15); expect_disp(1, "hexAF", 16'h00AF, 0);
    check("hex_noalu", aval_h, 0);

    press(0, 5'd5);
    @(negedge clk);
    check("pre_rst_dval", dval, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_dval", dval, 0);
    check("async_rst_dval_h", dval_h, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_disp(0, "rst2_disp", 16'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog");
  end

endmodule
